// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// LINK_BRANCH_EN adds the LINKBR state used by bneal/balv.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_RWB,
    S_BRANCH,
    S_ANDIEX,
    S_ANDIWB
`ifdef LINK_BRANCH_EN
    , S_LINKBR
`endif
  } state_t;

  typedef enum logic [2:0] {
    C_RFMT,
    C_LW,
    C_SW,
    C_BEQ,
    C_ANDI,
    C_BNEAL,
    C_BALV,
    C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RFMT  = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BNEAL = 6'b101101;
  localparam logic [5:0] OP_BALV  = 6'b100001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;

  localparam logic [1:0] B_REG   = 2'b00;
  localparam logic [1:0] B_FOUR  = 2'b01;
  localparam logic [1:0] B_IMM   = 2'b10;
  localparam logic [1:0] B_SHIMM = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decoder for the DECODE state.
// Without LINK_BRANCH_EN, bneal and balv fall through to illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output iclass_t    o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = C_ILLEGAL;
    case (i_opcode)
      OP_RFMT:  o_cls = C_RFMT;
      OP_LW:    o_cls = C_LW;
      OP_SW:    o_cls = C_SW;
      OP_BEQ:   o_cls = C_BEQ;
      OP_ANDI:  o_cls = C_ANDI;
`ifdef LINK_BRANCH_EN
      OP_BNEAL: o_cls = C_BNEAL;
      OP_BALV:  o_cls = C_BALV;
`endif
      default:  o_cls = C_ILLEGAL;
    endcase
  end

  assign o_illegal = (o_cls == C_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready handshake, timeout and retire counter.
// Define LINK_BRANCH_EN to enable bneal/balv (LINKBR state).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned MEM_TO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic             alusrca,
  output logic             regwrite,
  output logic             regdest,
  output logic [1:0]       pcsource,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             link,
  output logic             reg_31,
  output logic             b_invert,
  output logic             balv_s,
  output logic             illegal,
  output logic             mem_err,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
  localparam logic [WAIT_W-1:0] TO_LAST = (MEM_TO == 0) ? '0 : WAIT_W'(MEM_TO - 1);

  state_t            r_state;
  state_t            w_next;
  iclass_t           r_cls;
  iclass_t           w_dec_cls;
  logic              w_dec_ill;
  logic [WAIT_W-1:0] r_wait;
  logic              w_waiting;
  logic              w_timeout;
  logic              w_retire;
  logic              r_done;
  logic [CNT_W-1:0]  r_retired;

  ctrl_decode u_decode (
    .i_opcode  (opcode),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_ill)
  );

  // Counter is zero whenever a wait state is freshly entered, because it only
  // keeps counting while the FSM stays put in a not-ready wait state.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !mem_ready;
  assign w_timeout = (MEM_TO != 0) && w_waiting && (r_wait == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_START;
      r_cls     <= C_ILLEGAL;
      r_wait    <= '0;
      r_done    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      r_wait  <= (w_waiting && !w_timeout && (MEM_TO != 0)) ? r_wait + 1'b1 : '0;
      r_done  <= w_retire;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdest     = 1'b0;
    pcsource    = PC_ALU;
    alusrcb     = B_REG;
    aluop       = ALU_ADD;
    link        = 1'b0;
    reg_31      = 1'b0;
    b_invert    = 1'b0;
    balv_s      = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        memread  = 1'b1;
        alusrcb  = B_FOUR;
        aluop    = ALU_ADD;
        pcsource = PC_ALU;
        if (mem_ready) begin
          pcwrite = 1'b1;
          irwrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_START;
        end
      end
      S_DECODE: begin
        alusrcb = B_SHIMM;
        illegal = w_dec_ill;
        case (w_dec_cls)
          C_LW, C_SW: w_next = S_MEMADR;
          C_RFMT:     w_next = S_EXEC;
          C_BEQ:      w_next = S_BRANCH;
          C_ANDI:     w_next = S_ANDIEX;
`ifdef LINK_BRANCH_EN
          C_BNEAL, C_BALV: w_next = S_LINKBR;
`endif
          default:    w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = B_IMM;
        w_next  = (r_cls == C_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_START;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_START;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        w_next  = S_RWB;
      end
      S_RWB: begin
        regdest  = 1'b1;
        regwrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALU_SUB;
        pcwritecond = 1'b1;
        pcsource    = PC_ALUOUT;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_ANDIEX: begin
        alusrca = 1'b1;
        alusrcb = B_IMM;
        aluop   = ALU_AND;
        w_next  = S_ANDIWB;
      end
      S_ANDIWB: begin
        regwrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
`ifdef LINK_BRANCH_EN
      S_LINKBR: begin
        alusrca     = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = PC_ALUOUT;
        regwrite    = 1'b1;
        link        = 1'b1;
        reg_31      = 1'b1;
        if (r_cls == C_BNEAL) begin
          aluop    = ALU_SUB;
          b_invert = 1'b1;
        end else begin
          aluop  = ALU_ADD;
          balv_s = 1'b1;
        end
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
`endif
      default: w_next = S_START;
    endcase
  end

  assign mem_err    = w_timeout;
  assign instr_done = r_done;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output schedule model plus literal pins.
// Expectations follow LINK_BRANCH_EN the same way the DUT build does.
module tb_multicycle_control;

  localparam int TB_TO = 4;
`ifdef LINK_BRANCH_EN
  localparam int N_LINK = 2;
  localparam int N_ILL_LINK = 0;
`else
  localparam int N_LINK = 0;
  localparam int N_ILL_LINK = 2;
`endif

  localparam int T_START = 0, T_FETCH = 1, T_DEC = 2, T_MADR = 3, T_MRD = 4, T_MWB = 5,
                 T_MWR = 6, T_EXEC = 7, T_RWB = 8, T_BR = 9, T_AEX = 10, T_AWB = 11,
                 T_LNE = 12, T_LAL = 13;
  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ANDI = 4, K_BNEAL = 5,
                 K_BALV = 6, K_ILL = 7;

  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                alusrca, regwrite, regdest;
    logic [1:0] pcsource, alusrcb, aluop;
    logic       link, reg_31, b_invert, balv_s, illegal, mem_err, instr_done;
    logic [3:0] retired;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
  logic       alusrca, regwrite, regdest, link, reg_31, b_invert, balv_s;
  logic       illegal, mem_err, instr_done;
  logic [1:0] pcsource, alusrcb, aluop;
  logic [3:0] retired;
  ov_t        ov;

  int         checks = 0;
  int         failures = 0;
  int         cyc_n = 0;
  int         mw_cnt = 0;
  int         err_cnt = 0;
  int         ill_cnt = 0;
  logic [3:0] m_ret = '0;
  logic       m_done = 1'b0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(4), .MEM_TO(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .alusrca(alusrca),
    .regwrite(regwrite), .regdest(regdest), .pcsource(pcsource), .alusrcb(alusrcb),
    .aluop(aluop), .link(link), .reg_31(reg_31), .b_invert(b_invert), .balv_s(balv_s),
    .illegal(illegal), .mem_err(mem_err), .instr_done(instr_done), .retired(retired)
  );

  assign ov = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca,
               regwrite, regdest, pcsource, alusrcb, aluop, link, reg_31, b_invert, balv_s,
               illegal, mem_err, instr_done, retired};

  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic int m_class(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001100: return K_ANDI;
      6'b101101: return (N_LINK != 0) ? K_BNEAL : K_ILL;
      6'b100001: return (N_LINK != 0) ? K_BALV : K_ILL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic ov_t outs(input int t, input logic mr);
    ov_t o = '0;
    case (t)
      T_FETCH: begin o.memread = 1; o.alusrcb = 2'b01; o.pcwrite = mr; o.irwrite = mr; end
      T_DEC:   o.alusrcb = 2'b11;
      T_MADR:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      T_MRD:   begin o.memread = 1; o.iord = 1; end
      T_MWB:   begin o.regwrite = 1; o.memtoreg = 1; end
      T_MWR:   begin o.memwrite = 1; o.iord = 1; end
      T_EXEC:  begin o.alusrca = 1; o.aluop = 2'b10; end
      T_RWB:   begin o.regdest = 1; o.regwrite = 1; end
      T_BR:    begin o.alusrca = 1; o.aluop = 2'b01; o.pcwritecond = 1; o.pcsource = 2'b01; end
      T_AEX:   begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluop = 2'b11; end
      T_AWB:   o.regwrite = 1;
      T_LNE, T_LAL: begin
        o.alusrca = 1; o.pcwritecond = 1; o.pcsource = 2'b01; o.regwrite = 1;
        o.link = 1; o.reg_31 = 1;
        if (t == T_LNE) begin o.aluop = 2'b01; o.b_invert = 1; end
        else o.balv_s = 1;
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; outputs compared on the falling edge against the model.
  task automatic cyc(input string nm, input logic mr, input logic [5:0] op, input ov_t e,
                     input bit ret);
    mem_ready = mr;
    opcode    = op;
    e.instr_done = m_done;
    e.retired    = m_ret;
    @(negedge clk);
    checks++;
    if (ov !== e) begin
      failures++;
      $display("FAIL cyc%0d %s actual=%h required=%h", cyc_n, nm, ov, e);
    end
    if (memwrite) mw_cnt++;
    if (mem_err) err_cnt++;
    if (illegal) ill_cnt++;
    cyc_n++;
    @(posedge clk);
    #1;
    m_done = ret;
    if (ret) m_ret = m_ret + 4'd1;
  endtask

  task automatic wait_phase(input string nm, input int t, input int n, output bit ab);
    ov_t e;
    ab = 0;
    for (int i = 0; i < n; i++) begin
      if (i == TB_TO - 1) begin
        e = outs(t, 1'b0);
        e.mem_err = 1'b1;
        cyc({nm, "_timeout"}, 1'b0, rop(), e, 0);
        cyc("start_after_timeout", rmr(), rop(), '0, 0);
        ab = 1;
        return;
      end
      cyc({nm, "_wait"}, 1'b0, rop(), outs(t, 1'b0), 0);
    end
  endtask

  task automatic reset_seq(input int n);
    rst_n  = 1'b0;
    m_ret  = '0;
    m_done = 1'b0;
    for (int i = 0; i < n; i++) cyc("in_reset", rmr(), rop(), '0, 0);
    rst_n = 1'b1;
    cyc("start", rmr(), rop(), '0, 0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort_wb);
    bit  ab;
    int  k;
    ov_t e;
    wait_phase("fetch", T_FETCH, fw, ab);
    if (ab) return;
    cyc("fetch", 1'b1, rop(), outs(T_FETCH, 1'b1), 0);
    k = m_class(op);
    e = outs(T_DEC, 1'b0);
    e.illegal = (k == K_ILL);
    cyc("decode", rmr(), op, e, 0);
    case (k)
      K_LW: begin
        cyc("memadr", rmr(), rop(), outs(T_MADR, 1'b0), 0);
        wait_phase("memrd", T_MRD, mw, ab);
        if (ab) return;
        cyc("memrd", 1'b1, rop(), outs(T_MRD, 1'b1), 0);
        if (abort_wb) begin
          mem_ready = rmr();
          opcode    = rop();
          #2;
          check("pre_abort_regwrite", 32'(regwrite), 32'd1);
          rst_n = 1'b0;
          #1;
          check("abort_regwrite", 32'(regwrite), 32'd0);
          check("abort_memtoreg", 32'(memtoreg), 32'd0);
          check("abort_retired", 32'(retired), 32'd0);
          m_ret  = '0;
          m_done = 1'b0;
          cyc_n++;
          @(posedge clk);
          #1;
        end else begin
          cyc("memwb", rmr(), rop(), outs(T_MWB, 1'b0), 1);
        end
      end
      K_SW: begin
        cyc("memadr", rmr(), rop(), outs(T_MADR, 1'b0), 0);
        wait_phase("memwr", T_MWR, mw, ab);
        if (ab) return;
        cyc("memwr", 1'b1, rop(), outs(T_MWR, 1'b1), 1);
      end
      K_R: begin
        cyc("exec", rmr(), rop(), outs(T_EXEC, 1'b0), 0);
        cyc("rwb", rmr(), rop(), outs(T_RWB, 1'b0), 1);
      end
      K_BEQ:   cyc("branch", rmr(), rop(), outs(T_BR, 1'b0), 1);
      K_ANDI: begin
        cyc("andiex", rmr(), rop(), outs(T_AEX, 1'b0), 0);
        cyc("andiwb", rmr(), rop(), outs(T_AWB, 1'b0), 1);
      end
      K_BNEAL: cyc("linkbr_bneal", rmr(), rop(), outs(T_LNE, 1'b0), 1);
      K_BALV:  cyc("linkbr_balv", rmr(), rop(), outs(T_LAL, 1'b0), 1);
      default: ;
    endcase
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = '0;
    @(posedge clk);
    #1;
    reset_seq(3);

    run_instr(6'b100011, 0, 0, 0);
    check("lw_retired", 32'(retired), 32'd1);
    check("lw_done", 32'(instr_done), 32'd1);

    mw_cnt = 0;
    run_instr(6'b101011, 0, 3, 0);
    check("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    check("sw_done", 32'(instr_done), 32'd1);
    check("sw_retired", 32'(retired), 32'd2);

    run_instr(6'b000000, 2, 0, 0);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b001100, 1, 0, 0);
    run_instr(6'b101101, 0, 0, 0);
    run_instr(6'b100001, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    check("link_retired", 32'(retired), 32'(5 + N_LINK));
    check("illegal_pulses", 32'(ill_cnt), 32'(1 + N_ILL_LINK));

    run_instr(6'b000100, 4, 0, 0);
    check("fetch_timeout_err", 32'(err_cnt), 32'd1);
    run_instr(6'b000100, 3, 0, 0);
    check("late_ready_no_err", 32'(err_cnt), 32'd1);
    check("late_ready_retired", 32'(retired), 32'(6 + N_LINK));
    run_instr(6'b100011, 0, 4, 0);
    check("memrd_timeout_err", 32'(err_cnt), 32'd2);

    run_instr(6'b100011, 0, 1, 1);
    reset_seq(2);

    for (int i = 0; i < 15; i++) run_instr(6'b000100, 0, 0, 0);
    check("pre_wrap_retired", 32'(retired), 32'd15);
    run_instr(6'b000100, 0, 0, 0);
    check("wrap_retired", 32'(retired), 32'd0);
    check("wrap_done", 32'(instr_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
